// File: rtl/pll_reconf_seq.sv
// pll_reconf_seq: programs one of NUM_PROFILES PLL settings via reconfig mgmt.
// Optional build macro PLL_RECONF_SKIP_SAME_EN: skip reprogram of locked profile.
module pll_reconf_seq #(
  parameter int NUM_PROFILES = 2,
  parameter int NUM_CLOCKS   = 2,
  parameter int PW           = $clog2(NUM_PROFILES),
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req,
  input  logic [PW-1:0]                          req_profile,
  input  logic [NUM_PROFILES*(3+NUM_CLOCKS)*32-1:0] profile_tbl,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [PW-1:0]                          cur_profile,
  output logic [5:0]                             mgmt_address,
  output logic [31:0]                            mgmt_writedata,
  output logic                                   mgmt_write,
  input  logic                                   mgmt_waitrequest,
  input  logic                                   pll_locked
);

  localparam int NW  = 3 + NUM_CLOCKS;
  localparam int NT  = NUM_PROFILES * NW;
  localparam int TW  = $clog2(NT);
  localparam int WW  = $clog2(NUM_CLOCKS + 5);
  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int TOW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [WW-1:0] LAST = WW'(NUM_CLOCKS + 4);

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    WRITE,
    START,
    SETTLE,
    LOCK
  } state_t;

  state_t          state;
  logic [PW-1:0]   prof_q;
  logic [WW-1:0]   widx;
  logic [WW-1:0]   nidx;
  logic [SW-1:0]   scnt;
  logic [TOW-1:0]  tcnt;

  logic [31:0]     tbl_word [NT];
  logic [TW-1:0]   word_sel;
  logic [31:0]     sel_word;
  logic [4:0]      c_idx;
  logic [5:0]      nxt_addr;
  logic [31:0]     nxt_data;
  logic [31:0]     req_idx;
  logic            bad;
  logic            skip;

  for (genvar g = 0; g < NT; g++) begin : g_tbl
    assign tbl_word[g] = profile_tbl[g*32 +: 32];
  end

  // word index k>=1 of the sequence maps to table word k-1 (N,M,K,C0..)
  assign nidx     = widx + 1'b1;
  assign word_sel = TW'(int'(prof_q) * NW + int'(nidx) - 1);
  assign sel_word = tbl_word[word_sel];
  assign c_idx    = 5'(nidx - WW'(4));

  assign req_idx = 32'(req_profile);
  assign bad     = req_idx >= 32'(NUM_PROFILES);

`ifdef PLL_RECONF_SKIP_SAME_EN
  logic cur_valid;

  // cur_profile only means something after a real relock
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_valid <= 1'b0;
    end else if (state == LOCK && pll_locked) begin
      cur_valid <= 1'b1;
    end
  end

  assign skip = cur_valid && (req_profile == cur_profile) && pll_locked;
`else
  assign skip = 1'b0;
`endif

  // address/data of the word that follows the one just accepted
  always_comb begin
    nxt_addr = 6'h05;
    nxt_data = {9'b0, c_idx, sel_word[17:0]};
    unique case (1'b1)
      (nidx == WW'(1)): begin
        nxt_addr = 6'h03;
        nxt_data = sel_word;
      end
      (nidx == WW'(2)): begin
        nxt_addr = 6'h04;
        nxt_data = sel_word;
      end
      (nidx == WW'(3)): begin
        nxt_addr = 6'h07;
        nxt_data = sel_word;
      end
      (nidx == LAST): begin
        nxt_addr = 6'h02;
        nxt_data = 32'h0;
      end
      default: ;
    endcase
  end

  // sequencer: request, Avalon write burst, settle, lock wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cur_profile    <= '0;
      prof_q         <= '0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      widx           <= '0;
      scnt           <= '0;
      tcnt           <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              error <= 1'b1;
            end else if (skip) begin
              done <= 1'b1;
            end else begin
              prof_q         <= req_profile;
              state          <= MODE;
              busy           <= 1'b1;
              mgmt_write     <= 1'b1;
              mgmt_address   <= 6'h00;
              mgmt_writedata <= 32'h0;
              widx           <= '0;
            end
          end
        end
        MODE, WRITE, START: begin
          if (!mgmt_waitrequest) begin
            if (widx == LAST) begin
              // the accepted start cycle is the first ignored cycle
              mgmt_write <= 1'b0;
              scnt       <= SW'(1);
              tcnt       <= '0;
              state      <= (SETTLE_CYC > 1) ? SETTLE : LOCK;
            end else begin
              widx           <= nidx;
              mgmt_address   <= nxt_addr;
              mgmt_writedata <= nxt_data;
              state          <= (nidx == LAST) ? START : WRITE;
            end
          end
        end
        SETTLE: begin
          if (scnt >= SW'(SETTLE_CYC - 1)) begin
            state <= LOCK;
            tcnt  <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        LOCK: begin
          if (pll_locked) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            cur_profile <= prof_q;
            state       <= IDLE;
          end else if (tcnt == TOW'(LOCK_TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
